// File: rtl/calc_pkg.sv
// calc_pkg: state encoding and result/BCD geometry shared across the calculator datapath.
package calc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int RESULT_W = 8;
    localparam int BCD_DIGITS = 3;
    localparam int ONES_LSB = 0;
    localparam int TENS_LSB = 4;
    localparam int HUNDREDS_LSB = 8;
endpackage

// File: rtl/calc_result_bcd_add3.sv
// bcd_add3: double-dabble correction cell, adds 3 to any digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/calc_result_bcd.sv
// calc_result_bcd: sequential double-dabble binary-to-BCD converter with valid/ready handshake.
module calc_result_bcd
    import calc_pkg::*;
#(
    parameter int WIDTH = RESULT_W,
    parameter int NDIG  = BCD_DIGITS,
    parameter int CW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    result,
    input  logic                neg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   bcd,
    output logic                out_neg,
    output logic                busy
);
    localparam int BW = 4 * NDIG;

    state_t state, state_next;
    logic [CW-1:0] count;
    logic [BW+WIDTH-1:0] sreg, shifted;
    logic [BW-1:0] adj;
    logic neg_l, accept, last;

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_add3
            bcd_add3 u_add3 (.digit(sreg[WIDTH+4*i +: 4]), .adjusted(adj[4*i +: 4]));
        end
    endgenerate

    assign shifted = {adj[BW-2:0], sreg[WIDTH-1:0], 1'b0};
    assign last = count == CW'(WIDTH - 1);
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? SHIFT : IDLE;
            SHIFT:   state_next = last ? DONE : SHIFT;
            DONE:    state_next = out_ready ? (in_valid ? SHIFT : IDLE) : DONE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted so nothing is accepted during it
    always_comb begin
        in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
        out_valid = state == DONE;
        busy      = state == SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            sreg    <= '0;
            bcd     <= '0;
            out_neg <= 1'b0;
            neg_l   <= 1'b0;
        end else if (accept) begin
            sreg  <= {{BW{1'b0}}, result};
            count <= '0;
            neg_l <= neg & (|result);
        end else if (state == SHIFT) begin
            sreg  <= shifted;
            count <= count + CW'(1);
            if (last) begin
                bcd     <= shifted[BW+WIDTH-1 -: BW];
                out_neg <= neg_l;
            end
        end
    end
endmodule

// File: tb/tb_calc_result_bcd.sv
// tb_calc_result_bcd: randomized and directed checks against a decimal-arithmetic reference model.
module tb_calc_result_bcd;
    logic clk = 0, rst = 1, in_valid = 0, neg = 0, out_ready = 0;
    logic [7:0] result = 0;
    logic in_ready, out_valid, out_neg, busy;
    logic [11:0] bcd;
    int checks = 0, errors = 0;

    calc_result_bcd dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .neg(neg), .out_valid(out_valid), .out_ready(out_ready),
        .bcd(bcd), .out_neg(out_neg), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion in flight for WIDTH edges, then a held result until consumed.
    int m_left = 0;
    bit m_val = 0, m_neg = 0, p_neg = 0;
    int p_val = 0;
    logic [11:0] m_bcd = 0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_left = 0; m_val = 0; m_neg = 0; m_bcd = 0;
        end else begin
            acc = in_valid && m_left == 0 && (!m_val || out_ready);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val = 1; m_bcd = to_bcd(p_val); m_neg = p_neg;
                end
            end else if (m_val && out_ready) m_val = 0;
            if (acc) begin
                m_left = 8; p_val = int'(result); p_neg = neg && result != 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_bcd", 32'(bcd), 0);
            chk("rst_out_neg", 32'(out_neg), 0);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_val));
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("in_ready", 32'(in_ready), 32'(m_left == 0 && (!m_val || out_ready)));
            chk("bcd", 32'(bcd), 32'(m_bcd));
            chk("out_neg", 32'(out_neg), 32'(m_neg));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic convert(input logic [7:0] r, input logic n, output int lat);
        in_valid = 1; result = r; neg = n;
        step();
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt;
        repeat (2) step();
        rst = 0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 1);
        chk("post_reset_bcd", 32'(bcd), 0);

        out_ready = 1;
        convert(8'd255, 1'b0, lat);
        chk("lat_255", 32'(lat), 8);
        chk("bcd_255", 32'(bcd), 32'h255);
        chk("neg_255", 32'(out_neg), 0);
        step();
        chk("valid_drop_255", 32'(out_valid), 0);

        convert(8'd0, 1'b1, lat);
        chk("bcd_negzero", 32'(bcd), 32'h000);
        chk("neg_negzero", 32'(out_neg), 0);
        step();

        convert(8'd2, 1'b1, lat);
        chk("bcd_2", 32'(bcd), 32'h002);
        chk("neg_2", 32'(out_neg), 1);
        step();

        out_ready = 0;
        convert(8'd80, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            chk("hold_bcd_80", 32'(bcd), 32'h080);
            chk("hold_in_ready", 32'(in_ready), 0);
            step();
        end
        out_ready = 1;
        convert(8'd7, 1'b0, lat);
        chk("b2b_lat", 32'(lat), 8);
        chk("bcd_7", 32'(bcd), 32'h007);
        step();

        in_valid = 1; result = 8'd199; neg = 0;
        step();
        in_valid = 0;
        repeat (4) step();
        rst = 1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_bcd", 32'(bcd), 0);
        repeat (2) step();
        rst = 0;
        bcnt = 0;
        repeat (12) begin
            step();
            if (out_valid) bcnt++;
        end
        chk("no_pulse_after_rst", 32'(bcnt), 0);
        convert(8'd199, 1'b0, lat);
        chk("bcd_199", 32'(bcd), 32'h199);
        step();

        in_valid = 1; result = 8'd64; neg = 0;
        step();
        in_valid = 0;
        bcnt = 0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            if (busy) bcnt++;
            result = 8'($urandom);
            step();
        end
        chk("busy_cycles", 32'(bcnt), 8);
        chk("bcd_64", 32'(bcd), 32'h064);
        step();

        for (int i = 0; i < 1500; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            result = 8'($urandom);
            neg = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 9) < 7;
            rst = $urandom_range(0, 299) == 0;
            step();
        end
        rst = 0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
